uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter among NUM_REQ byte-stream requesters (e.g. CPU MMIO, debug, trace).

---
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester and transmitter handshake bundle for uart_tx_arbiter.
//               master = requesters plus transmitter side, slave = arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;

    modport master (
        output req_data, req_valid, req_last, tx_ready,
        input  req_ready, tx_data, tx_valid, grant, busy
    );

    modport slave (
        input  req_data, req_valid, req_last, tx_ready,
        output req_ready, tx_data, tx_valid, grant, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one UART transmitter among
//               NUM_REQ byte streams. A grant is locked until the owner's
//               last byte, MAX_BURST bytes, or IDLE_TIMEOUT idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    uart_tx_arbiter_if.slave  bus
);
    localparam int OW = (NUM_REQ > 1)      ? $clog2(NUM_REQ)      : 1;
    localparam int BW = (MAX_BURST > 1)    ? $clog2(MAX_BURST)    : 1;
    localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic          HAS_BURST  = (MAX_BURST != 0);
    localparam logic          HAS_TMO    = (IDLE_TIMEOUT != 0);
    localparam logic [BW-1:0] BURST_LAST = BW'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
    localparam logic [IW-1:0] IDLE_LAST  = IW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [OW-1:0]       last_owner_q, last_owner_d;
    logic [BW-1:0]       burst_cnt_q, burst_cnt_d;
    logic [IW-1:0]       idle_cnt_q, idle_cnt_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                busy_q, busy_d;

    logic                pick_found;
    logic [OW-1:0]       pick_idx;
    logic                owner_valid;
    logic                owner_last;
    logic [7:0]          owner_data;
    logic                xfer;
    logic                release_now;

    // Round-robin pick: first valid requester after last_owner, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(last_owner_q) + k) % NUM_REQ;
            if (!pick_found && bus.req_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = OW'(idx);
            end
        end
    end

    // Owner-selected datapath towards the transmitter, no added latency.
    always_comb begin
        owner_valid   = 1'b0;
        owner_last    = 1'b0;
        owner_data    = 8'h00;
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == OW'(i)) begin
                owner_valid = bus.req_valid[i];
                owner_last  = bus.req_last[i];
                owner_data  = bus.req_data[8*i +: 8];
                bus.req_ready[i] = (state_q == ST_LOCK) && bus.tx_ready;
            end
        end
        bus.tx_valid = (state_q == ST_LOCK) && owner_valid;
        bus.tx_data  = (state_q == ST_LOCK) ? owner_data : 8'h00;
        xfer         = bus.tx_valid && bus.tx_ready;
    end

    // Next-state logic: grant in IDLE, release on last/burst limit/timeout.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        release_now  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d     = ST_LOCK;
                    owner_d     = pick_idx;
                    grant_d     = NUM_REQ'(1) << pick_idx;
                    busy_d      = 1'b1;
                    burst_cnt_d = '0;
                    idle_cnt_d  = '0;
                end
            end
            ST_LOCK: begin
                if (xfer) begin
                    // Saturate rather than wrap when the burst limit is disabled.
                    if (burst_cnt_q != '1) begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                    if (owner_last || (HAS_BURST && (burst_cnt_q == BURST_LAST))) begin
                        release_now = 1'b1;
                    end
                end
                if (owner_valid) begin
                    idle_cnt_d = '0;
                end else begin
                    if (idle_cnt_q != '1) begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                    if (HAS_TMO && (idle_cnt_q == IDLE_LAST)) begin
                        release_now = 1'b1;
                    end
                end
                if (release_now) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                    grant_d      = '0;
                    busy_d       = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset makes requester 0 the first winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
            idle_cnt_q   <= '0;
            grant_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter
//               (NUM_REQ=4, MAX_BURST=16, IDLE_TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
    logic clk;
    logic rst_n;

    uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .MAX_BURST    (16),
        .IDLE_TIMEOUT (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Per-requester byte sources: {last, data}
    logic [8:0] src [4][32];
    int         len [4];
    int         ptr [4];
    logic       bp;

    logic [7:0] log_data[$];
    int         log_src[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] g);
        for (int i = 0; i < 4; i++) begin
            if (g == (4'b0001 << i)) return i;
        end
        return -1;
    endfunction

    task automatic push(input int i, input logic [8:0] v);
        src[i][len[i]] = v;
        len[i]++;
    endtask

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            if (ptr[i] < len[i]) begin
                bus.req_valid[i]       = 1'b1;
                bus.req_last[i]        = src[i][ptr[i]][8];
                bus.req_data[8*i +: 8] = src[i][ptr[i]][7:0];
            end else begin
                bus.req_valid[i]       = 1'b0;
                bus.req_last[i]        = 1'b0;
                bus.req_data[8*i +: 8] = 8'h00;
            end
        end
    endtask

    // One clock: sample at negedge, advance sources just after posedge.
    task automatic tick();
        logic [3:0] acc;
        @(negedge clk);
        acc = bus.req_valid & bus.req_ready;
        if (bus.tx_valid && bus.tx_ready) begin
            log_data.push_back(bus.tx_data);
            log_src.push_back(oh2idx(bus.grant));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) ptr[i]++;
        end
        if (bp) bus.tx_ready = ~bus.tx_ready;
        refresh();
    endtask

    task automatic run_until(input string tag, input int n, input int budget);
        int b;
        b = 0;
        while (log_data.size() < n && b < budget) begin
            tick();
            b++;
        end
        chk(tag, 32'(log_data.size()), 32'(n));
    endtask

    task automatic chk_log(input string tag, input int k, input int exp_src, input logic [7:0] exp_data);
        chk({tag, "_src"},  32'(log_src[k]),  32'(exp_src));
        chk({tag, "_data"}, 32'(log_data[k]), 32'(exp_data));
    endtask

    initial begin
        bp            = 1'b0;
        rst_n         = 1'b0;
        bus.tx_ready  = 1'b1;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        for (int i = 0; i < 4; i++) begin
            len[i] = 0;
            ptr[i] = 0;
        end

        // ---- Reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant",    32'(bus.grant),     32'h0);
        chk("rst_busy",     32'(bus.busy),      32'h0);
        chk("rst_tx_valid", 32'(bus.tx_valid),  32'h0);
        chk("rst_tx_data",  32'(bus.tx_data),   32'h0);
        chk("rst_req_rdy",  32'(bus.req_ready), 32'h0);
        rst_n = 1'b1;

        // ---- Round robin with 1-byte packets ----
        push(0, 9'h1A0); push(0, 9'h1A0);
        push(1, 9'h1A1); push(2, 9'h1A2); push(3, 9'h1A3);
        refresh();
        tick();
        chk("first_grant",    32'(bus.grant),     32'h1);
        chk("first_busy",     32'(bus.busy),      32'h1);
        chk("first_tx_valid", 32'(bus.tx_valid),  32'h1);
        chk("first_tx_data",  32'(bus.tx_data),   32'hA0);
        chk("first_req_rdy",  32'(bus.req_ready), 32'h1);
        run_until("rr_count", 5, 30);
        chk_log("rr0", 0, 0, 8'hA0);
        chk_log("rr1", 1, 1, 8'hA1);
        chk_log("rr2", 2, 2, 8'hA2);
        chk_log("rr3", 3, 3, 8'hA3);
        chk_log("rr4", 4, 0, 8'hA0);
        chk("rr_end_grant", 32'(bus.grant), 32'h0);
        chk("rr_end_busy",  32'(bus.busy),  32'h0);

        // ---- Packet lock with transmitter back-pressure ----
        log_data.delete(); log_src.delete();
        push(1, 9'h011); push(1, 9'h022); push(1, 9'h133);
        push(2, 9'h155);
        refresh();
        bp = 1'b1;
        run_until("lock_count", 4, 40);
        chk_log("lock0", 0, 1, 8'h11);
        chk_log("lock1", 1, 1, 8'h22);
        chk_log("lock2", 2, 1, 8'h33);
        chk_log("lock3", 3, 2, 8'h55);
        bp = 1'b0;
        bus.tx_ready = 1'b1;

        // ---- Burst limit: 20 bytes from req0, req3 waiting ----
        log_data.delete(); log_src.delete();
        for (int k = 0; k < 20; k++) push(0, {1'b0, 8'(8'h40 + k)});
        refresh();
        tick();
        chk("burst_grant0", 32'(bus.grant), 32'h1);
        push(3, 9'h1D3);
        refresh();
        run_until("burst_count", 21, 60);
        for (int k = 0; k < 16; k++) chk_log("burst_a", k, 0, 8'(8'h40 + k));
        chk_log("burst_r3", 16, 3, 8'hD3);
        for (int k = 17; k < 21; k++) chk_log("burst_b", k, 0, 8'(8'h40 + k - 1));
        repeat (12) tick();
        chk("burst_tmo_busy",  32'(bus.busy),  32'h0);
        chk("burst_tmo_grant", 32'(bus.grant), 32'h0);

        // ---- Idle timeout ----
        log_data.delete(); log_src.delete();
        push(2, 9'h077);
        refresh();
        tick();
        chk("tmo_grant2", 32'(bus.grant), 32'h4);
        run_until("tmo_first", 1, 5);
        push(0, 9'h199);
        refresh();
        repeat (7) tick();
        chk("tmo_hold_busy",  32'(bus.busy),  32'h1);
        chk("tmo_hold_grant", 32'(bus.grant), 32'h4);
        tick();
        chk("tmo_rel_busy",  32'(bus.busy),  32'h0);
        chk("tmo_rel_grant", 32'(bus.grant), 32'h0);
        tick();
        chk("tmo_next_grant", 32'(bus.grant), 32'h1);
        run_until("tmo_count", 2, 5);
        chk_log("tmo0", 0, 2, 8'h77);
        chk_log("tmo1", 1, 0, 8'h99);

        // ---- Asynchronous reset mid-packet ----
        log_data.delete(); log_src.delete();
        push(3, 9'h061); push(3, 9'h062); push(3, 9'h163);
        refresh();
        run_until("ar_first", 1, 5);
        chk_log("ar_pre", 0, 3, 8'h61);
        push(1, 9'h1E1);
        refresh();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_grant",    32'(bus.grant),     32'h0);
        chk("ar_busy",     32'(bus.busy),      32'h0);
        chk("ar_tx_valid", 32'(bus.tx_valid),  32'h0);
        chk("ar_tx_data",  32'(bus.tx_data),   32'h0);
        chk("ar_req_rdy",  32'(bus.req_ready), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        log_data.delete(); log_src.delete();
        run_until("ar_count", 3, 20);
        chk_log("ar0", 0, 1, 8'hE1);
        chk_log("ar1", 1, 3, 8'h62);
        chk_log("ar2", 2, 3, 8'h63);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
